// File: rtl/router_pkt_receiver.sv
// Router output-port consumer: reads one packet at a time from the router FIFO,
// forwards header/payload bytes with sop/eop markers, checks parity and counts packets/errors.
module router_pkt_receiver #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  input  logic        sink_ready,
  output logic        read_enb,
  output logic [7:0]  pkt_byte,
  output logic        pkt_byte_valid,
  output logic        pkt_sop,
  output logic        pkt_eop,
  output logic        pkt_done,
  output logic [5:0]  pkt_len,
  output logic [1:0]  pkt_addr,
  output logic        parity_ok,
  output logic        pkt_abort,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0]  WD_LIMIT = 8'(TIMEOUT);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  logic [1:0]  state_q, state_d;
  logic [6:0]  rd_left_q, rd_left_d;
  logic [6:0]  cap_left_q, cap_left_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  wd_q, wd_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        pok_q, pok_d;
  logic [5:0]  len_q, len_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic [7:0]  wd_inc;

  // Next-state, datapath and read-strobe logic
  always_comb begin
    state_d    = state_q;
    rd_left_d  = rd_left_q;
    cap_left_d = cap_left_q;
    acc_d      = acc_q;
    wd_d       = wd_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    pok_d      = 1'b0;
    len_d      = len_q;
    addr_d     = addr_q;
    pcnt_d     = pcnt_q;
    ecnt_d     = ecnt_q;
    read_enb   = 1'b0;
    wd_inc     = wd_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        wd_d     = 8'd0;
        read_enb = vld_out & sink_ready;
        if (read_enb) state_d = S_HDR;
      end
      S_HDR: begin
        len_d      = data_out[7:2];
        addr_d     = data_out[1:0];
        acc_d      = data_out;
        rd_left_d  = 7'({1'b0, data_out[7:2]}) + 7'd1;
        cap_left_d = 7'({1'b0, data_out[7:2]}) + 7'd1;
        byte_d     = data_out;
        valid_d    = 1'b1;
        sop_d      = 1'b1;
        eop_d      = (data_out[7:2] == 6'd0);
        wd_d       = 8'd0;
        state_d    = S_BODY;
      end
      S_BODY: begin
        if (rd_pend_q) begin
          wd_d       = 8'd0;
          cap_left_d = cap_left_q - 7'd1;
          if (cap_left_q == 7'd1) begin
            // Parity byte: compare only, never forwarded
            done_d  = 1'b1;
            pok_d   = (acc_q == data_out);
            state_d = S_DONE;
            if (acc_q == data_out) begin
              if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + 16'd1;
            end else begin
              if (ecnt_q != CNT_MAX) ecnt_d = ecnt_q + 16'd1;
            end
          end else begin
            acc_d   = acc_q ^ data_out;
            byte_d  = data_out;
            valid_d = 1'b1;
            eop_d   = (cap_left_q == 7'd2);
          end
        end else if (wd_inc >= WD_LIMIT) begin
          abort_d = 1'b1;
          wd_d    = 8'd0;
          state_d = S_IDLE;
          if (ecnt_q != CNT_MAX) ecnt_d = ecnt_q + 16'd1;
        end else begin
          wd_d = wd_inc;
        end
        if (!abort_d) begin
          read_enb = (rd_left_q != 7'd0) & vld_out & sink_ready;
          if (read_enb) rd_left_d = rd_left_q - 7'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rd_pend_d = read_enb & (state_q == S_BODY);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rd_left_q  <= 7'd0;
      cap_left_q <= 7'd0;
      rd_pend_q  <= 1'b0;
      acc_q      <= 8'd0;
      wd_q       <= 8'd0;
      byte_q     <= 8'd0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      pok_q      <= 1'b0;
      len_q      <= 6'd0;
      addr_q     <= 2'd0;
      pcnt_q     <= 16'd0;
      ecnt_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      rd_left_q  <= rd_left_d;
      cap_left_q <= cap_left_d;
      rd_pend_q  <= rd_pend_d;
      acc_q      <= acc_d;
      wd_q       <= wd_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      pok_q      <= pok_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      pcnt_q     <= pcnt_d;
      ecnt_q     <= ecnt_d;
    end
  end

  assign pkt_byte       = byte_q;
  assign pkt_byte_valid = valid_q;
  assign pkt_sop        = sop_q;
  assign pkt_eop        = eop_q;
  assign pkt_done       = done_q;
  assign pkt_abort      = abort_q;
  assign parity_ok      = pok_q;
  assign pkt_len        = len_q;
  assign pkt_addr       = addr_q;
  assign pkt_count      = pcnt_q;
  assign err_count      = ecnt_q;

endmodule

// File: tb/tb_router_pkt_receiver.sv
// Directed bench for router_pkt_receiver: a behavioural router FIFO feeds packets,
// a negedge monitor records traffic, and each scenario task checks its own results.
module tb_router_pkt_receiver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vld_out;
  logic [7:0]  data_out = 8'd0;
  logic        sink_ready = 1'b0;
  logic        read_enb;
  logic [7:0]  pkt_byte;
  logic        pkt_byte_valid, pkt_sop, pkt_eop, pkt_done;
  logic [5:0]  pkt_len;
  logic [1:0]  pkt_addr;
  logic        parity_ok, pkt_abort;
  logic [15:0] pkt_count, err_count;

  int asserts = 0;
  int fails   = 0;

  router_pkt_receiver #(.TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out),
    .sink_ready(sink_ready), .read_enb(read_enb), .pkt_byte(pkt_byte),
    .pkt_byte_valid(pkt_byte_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_addr(pkt_addr),
    .parity_ok(parity_ok), .pkt_abort(pkt_abort), .pkt_count(pkt_count),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  // Behavioural router FIFO: data valid the cycle after read_enb
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       vld_en = 1'b0;
  assign vld_out = vld_en && (rd_ptr != wr_ptr);

  always @(posedge clock) begin
    if (read_enb) begin
      data_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 8'd1;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor
  int         n_reads = 0;
  int         read_cyc [0:1023];
  int         rx_n = 0;
  logic [7:0] rx_byte [0:1023];
  logic       rx_sop [0:1023];
  logic       rx_eop [0:1023];
  int         rx_cyc [0:1023];
  int         done_n = 0;
  int         done_cyc = 0;
  logic       last_pok = 1'b0;
  int         abort_n = 0;
  int         bp_viol = 0;

  always @(negedge clock) begin
    if (read_enb) begin
      read_cyc[n_reads] = cyc;
      n_reads++;
    end
    if (pkt_byte_valid) begin
      rx_byte[rx_n] = pkt_byte;
      rx_sop[rx_n]  = pkt_sop;
      rx_eop[rx_n]  = pkt_eop;
      rx_cyc[rx_n]  = cyc;
      rx_n++;
    end
    if (pkt_done) begin
      done_n++;
      done_cyc = cyc;
      last_pok = parity_ok;
    end
    if (pkt_abort) abort_n++;
    if (!sink_ready && read_enb) bp_viol++;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  task automatic wait_for(input int tgt_done, input int tgt_abort, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      if (done_n >= tgt_done && abort_n >= tgt_abort) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; vld_en = 1'b0; sink_ready = 1'b0;
    tick(3);
    asserts++;
    if ({read_enb, pkt_byte_valid, pkt_sop, pkt_eop, pkt_done, pkt_abort, parity_ok} !== 7'b0) begin
      $display("FAIL reset_flags got=%b exp=0", {read_enb, pkt_byte_valid, pkt_sop, pkt_eop, pkt_done, pkt_abort, parity_ok});
      fails++;
    end
    asserts++;
    if ({pkt_byte, pkt_len, pkt_addr} !== 16'h0) begin
      $display("FAIL reset_fields got=%h exp=0", {pkt_byte, pkt_len, pkt_addr});
      fails++;
    end
    asserts++;
    if ({pkt_count, err_count} !== 32'h0) begin
      $display("FAIL reset_counters got=%h exp=0", {pkt_count, err_count});
      fails++;
    end
    reset = 1'b0;
    sink_ready = 1'b1;
    tick(1);
  endtask

  task automatic test_good_packet();
    logic [7:0] exp_b [0:3];
    int r0, x0, d0;
    bit ok;
    exp_b[0] = 8'h0D; exp_b[1] = 8'h11; exp_b[2] = 8'h22; exp_b[3] = 8'h33;
    r0 = n_reads; x0 = rx_n; d0 = done_n;
    push(8'h0D); push(8'h11); push(8'h22); push(8'h33); push(8'h0D);
    vld_en = 1'b1;
    wait_for(d0 + 1, 0, ok);
    asserts++;
    if (!ok) begin $display("FAIL good_done_timeout got=%0d exp=%0d", done_n, d0 + 1); fails++; end
    tick(2);
    asserts++;
    if (rx_n - x0 !== 4) begin $display("FAIL good_byte_count got=%0d exp=4", rx_n - x0); fails++; end
    for (int i = 0; i < 4; i++) begin
      asserts++;
      if ({rx_byte[x0+i], rx_sop[x0+i], rx_eop[x0+i]} !== {exp_b[i], i == 0, i == 3}) begin
        $display("FAIL good_byte%0d got=%h/%b/%b exp=%h/%b/%b", i, rx_byte[x0+i], rx_sop[x0+i],
                 rx_eop[x0+i], exp_b[i], i == 0, i == 3);
        fails++;
      end
    end
    asserts++;
    if (last_pok !== 1'b1) begin $display("FAIL good_parity_ok got=%b exp=1", last_pok); fails++; end
    asserts++;
    if ({pkt_len, pkt_addr} !== {6'd3, 2'd1}) begin
      $display("FAIL good_len_addr got=%0d/%0d exp=3/1", pkt_len, pkt_addr); fails++;
    end
    asserts++;
    if ({pkt_count, err_count} !== {16'd1, 16'd0}) begin
      $display("FAIL good_counts got=%0d/%0d exp=1/0", pkt_count, err_count); fails++;
    end
    asserts++;
    if (rx_cyc[x0] - read_cyc[r0] !== 2) begin
      $display("FAIL good_hdr_latency got=%0d exp=2", rx_cyc[x0] - read_cyc[r0]); fails++;
    end
    asserts++;
    if (done_cyc - read_cyc[r0] !== 7) begin
      $display("FAIL good_done_latency got=%0d exp=7", done_cyc - read_cyc[r0]); fails++;
    end
  endtask

  task automatic test_bad_parity();
    int d0;
    bit ok;
    d0 = done_n;
    push(8'h0D); push(8'h11); push(8'h22); push(8'h33); push(8'hFF);
    wait_for(d0 + 1, 0, ok);
    asserts++;
    if (!ok) begin $display("FAIL bad_done_timeout got=%0d exp=%0d", done_n, d0 + 1); fails++; end
    asserts++;
    if (last_pok !== 1'b0) begin $display("FAIL bad_parity_ok got=%b exp=0", last_pok); fails++; end
    asserts++;
    if ({pkt_count, err_count} !== {16'd1, 16'd1}) begin
      $display("FAIL bad_counts got=%0d/%0d exp=1/1", pkt_count, err_count); fails++;
    end
    tick(2);
  endtask

  task automatic test_len_zero();
    int d0, x0;
    bit ok;
    d0 = done_n; x0 = rx_n;
    push(8'h02); push(8'h02);
    wait_for(d0 + 1, 0, ok);
    asserts++;
    if (!ok) begin $display("FAIL len0_done_timeout got=%0d exp=%0d", done_n, d0 + 1); fails++; end
    tick(2);
    asserts++;
    if (rx_n - x0 !== 1) begin $display("FAIL len0_byte_count got=%0d exp=1", rx_n - x0); fails++; end
    asserts++;
    if ({rx_byte[x0], rx_sop[x0], rx_eop[x0]} !== {8'h02, 1'b1, 1'b1}) begin
      $display("FAIL len0_byte got=%h/%b/%b exp=02/1/1", rx_byte[x0], rx_sop[x0], rx_eop[x0]); fails++;
    end
    asserts++;
    if ({last_pok, pkt_len, pkt_addr} !== {1'b1, 6'd0, 2'd2}) begin
      $display("FAIL len0_status got=%b/%0d/%0d exp=1/0/2", last_pok, pkt_len, pkt_addr); fails++;
    end
    asserts++;
    if (pkt_count !== 16'd2) begin $display("FAIL len0_pkt_count got=%0d exp=2", pkt_count); fails++; end
  endtask

  task automatic test_back_to_back();
    int d0, r0;
    bit ok;
    d0 = done_n; r0 = n_reads;
    push(8'h02); push(8'h02);
    push(8'h05); push(8'hAA); push(8'hAF);
    wait_for(d0 + 2, 0, ok);
    asserts++;
    if (!ok) begin $display("FAIL b2b_done_timeout got=%0d exp=%0d", done_n, d0 + 2); fails++; end
    tick(2);
    asserts++;
    if (read_cyc[r0+2] - read_cyc[r0] !== 5) begin
      $display("FAIL b2b_hdr_gap got=%0d exp=5", read_cyc[r0+2] - read_cyc[r0]); fails++;
    end
    asserts++;
    if ({pkt_count, err_count, pkt_len, pkt_addr} !== {16'd4, 16'd1, 6'd1, 2'd1}) begin
      $display("FAIL b2b_status got=%0d/%0d/%0d/%0d exp=4/1/1/1", pkt_count, err_count, pkt_len, pkt_addr);
      fails++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [0:5];
    int d0, x0, r0, v0;
    bit ok, seen;
    exp_b[0] = 8'h17; exp_b[1] = 8'h01; exp_b[2] = 8'h02;
    exp_b[3] = 8'h03; exp_b[4] = 8'h04; exp_b[5] = 8'h05;
    d0 = done_n; x0 = rx_n; r0 = n_reads; v0 = bp_viol;
    for (int i = 0; i < 6; i++) push(exp_b[i]);
    push(8'h16);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (n_reads - r0 >= 3) begin seen = 1'b1; break; end
    end
    sink_ready = 1'b0;
    asserts++;
    if (!seen) begin $display("FAIL bp_third_read got=%0d exp=3", n_reads - r0); fails++; end
    tick(10);
    asserts++;
    if (rx_n - x0 !== 3) begin $display("FAIL bp_bytes_in_stall got=%0d exp=3", rx_n - x0); fails++; end
    asserts++;
    if (n_reads - r0 !== 3) begin $display("FAIL bp_reads_in_stall got=%0d exp=3", n_reads - r0); fails++; end
    sink_ready = 1'b1;
    wait_for(d0 + 1, 0, ok);
    asserts++;
    if (!ok) begin $display("FAIL bp_done_timeout got=%0d exp=%0d", done_n, d0 + 1); fails++; end
    tick(2);
    asserts++;
    if (bp_viol - v0 !== 0) begin $display("FAIL bp_read_while_stalled got=%0d exp=0", bp_viol - v0); fails++; end
    asserts++;
    if (rx_n - x0 !== 6) begin $display("FAIL bp_byte_count got=%0d exp=6", rx_n - x0); fails++; end
    for (int i = 0; i < 6; i++) begin
      asserts++;
      if (rx_byte[x0+i] !== exp_b[i]) begin
        $display("FAIL bp_byte%0d got=%h exp=%h", i, rx_byte[x0+i], exp_b[i]); fails++;
      end
    end
    asserts++;
    if ({last_pok, pkt_count} !== {1'b1, 16'd5}) begin
      $display("FAIL bp_status got=%b/%0d exp=1/5", last_pok, pkt_count); fails++;
    end
  endtask

  task automatic test_abort();
    int d0, a0;
    bit ok;
    d0 = done_n; a0 = abort_n;
    push(8'h14); push(8'hAA); push(8'hBB);
    wait_for(0, a0 + 1, ok);
    asserts++;
    if (!ok) begin $display("FAIL abort_timeout got=%0d exp=%0d", abort_n, a0 + 1); fails++; end
    tick(3);
    asserts++;
    if (abort_n - a0 !== 1) begin $display("FAIL abort_pulses got=%0d exp=1", abort_n - a0); fails++; end
    asserts++;
    if (done_n - d0 !== 0) begin $display("FAIL abort_no_done got=%0d exp=0", done_n - d0); fails++; end
    asserts++;
    if ({pkt_count, err_count} !== {16'd5, 16'd2}) begin
      $display("FAIL abort_counts got=%0d/%0d exp=5/2", pkt_count, err_count); fails++;
    end
    // A later good packet proves the receiver is back in IDLE
    push(8'h02); push(8'h02);
    wait_for(d0 + 1, 0, ok);
    tick(1);
    asserts++;
    if ({ok, last_pok, pkt_count} !== {1'b1, 1'b1, 16'd6}) begin
      $display("FAIL abort_recover got=%b/%b/%0d exp=1/1/6", ok, last_pok, pkt_count); fails++;
    end
  endtask

  task automatic test_midpkt_reset();
    int d0, r0;
    bit ok, seen;
    d0 = done_n; r0 = n_reads;
    push(8'h16); push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05); push(8'h17);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (n_reads - r0 >= 3) begin seen = 1'b1; break; end
    end
    vld_en = 1'b0;
    reset  = 1'b1;
    tick(1);
    reset  = 1'b0;
    asserts++;
    if (!seen) begin $display("FAIL rst_reach_body got=%0d exp=3", n_reads - r0); fails++; end
    asserts++;
    if ({read_enb, pkt_byte_valid, pkt_sop, pkt_eop, pkt_done, pkt_abort, parity_ok, pkt_byte, pkt_len, pkt_addr} !== 23'd0) begin
      $display("FAIL rst_outputs got=%h exp=0",
               {read_enb, pkt_byte_valid, pkt_sop, pkt_eop, pkt_done, pkt_abort, parity_ok, pkt_byte, pkt_len, pkt_addr});
      fails++;
    end
    asserts++;
    if ({pkt_count, err_count} !== 32'd0) begin
      $display("FAIL rst_counters got=%0d/%0d exp=0/0", pkt_count, err_count); fails++;
    end
    tick(2);
    wr_ptr = rd_ptr;
    push(8'h0D); push(8'h11); push(8'h22); push(8'h33); push(8'h0D);
    vld_en = 1'b1;
    wait_for(d0 + 1, 0, ok);
    tick(1);
    asserts++;
    if ({ok, last_pok, pkt_count, err_count, pkt_len, pkt_addr} !== {1'b1, 1'b1, 16'd1, 16'd0, 6'd3, 2'd1}) begin
      $display("FAIL rst_recover got=%b/%b/%0d/%0d/%0d/%0d exp=1/1/1/0/3/1",
               ok, last_pok, pkt_count, err_count, pkt_len, pkt_addr);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_len_zero();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_midpkt_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
